// File: rtl/score_text_writer.sv
// score_text_writer: owns the write port of the 2x80 score text buffer.
// After reset it fills the buffer with spaces and writes the "SCORE" label.
// On each score update it converts the saturated binary score to BCD with a
// sequential double-dabble and writes the digit characters, MS digit first.
module score_text_writer #(
   parameter int SCORE_W   = 20,
   parameter int DIGITS    = 6,
   parameter int COLS      = 80,
   parameter int ROWS      = 2,
   parameter int LABEL_COL = 0,
   parameter int SCORE_COL = 7
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [SCORE_W-1:0] score,
   input  logic               score_valid,
   output logic [7:0]         wr_addr,
   output logic [7:0]         wr_data,
   output logic               we,
   output logic               busy
);

   localparam int DEPTH     = COLS * ROWS;
   localparam int MAX_SCORE = 10**DIGITS - 1;
   localparam int BCD_W     = 4 * DIGITS;
   localparam int IW        = $clog2(SCORE_W);
   localparam int DW        = $clog2(DIGITS + 1);

   typedef enum logic [2:0] {CLEAR, LABEL, IDLE, CONV, WRITE} state_t;

   state_t             state, state_n;
   logic [7:0]         clr_cnt, clr_cnt_n;
   logic [2:0]         lbl_cnt, lbl_cnt_n;
   logic [IW-1:0]      iter_cnt, iter_cnt_n;
   logic [DW-1:0]      dig_cnt, dig_cnt_n;
   logic               pend, pend_n;
   logic [SCORE_W-1:0] pend_val, pend_val_n;
   logic [SCORE_W-1:0] bin, bin_n;
   logic [BCD_W-1:0]   bcd, bcd_n, adj;
   logic [7:0]         wr_addr_n, wr_data_n;
   logic               we_n, busy_n;
   logic               exit_pt, start;
   logic [SCORE_W-1:0] start_val, sat_val;

   // Clamp scores that cannot be shown in DIGITS decimal places.
   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
      if (v > SCORE_W'(MAX_SCORE))
         return SCORE_W'(MAX_SCORE);
      return v;
   endfunction

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Character codes of the "SCORE" label.
   function automatic logic [7:0] label_char(input logic [2:0] idx);
      case (idx)
         3'd0:    return 8'h53;
         3'd1:    return 8'h43;
         3'd2:    return 8'h4F;
         3'd3:    return 8'h52;
         default: return 8'h45;
      endcase
   endfunction

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_n    = state;
      clr_cnt_n  = clr_cnt;
      lbl_cnt_n  = lbl_cnt;
      iter_cnt_n = iter_cnt;
      dig_cnt_n  = dig_cnt;
      pend_n     = pend;
      pend_val_n = pend_val;
      bin_n      = bin;
      bcd_n      = bcd;
      adj        = '0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      we_n       = 1'b0;
      busy_n     = 1'b1;
      exit_pt    = 1'b0;
      start      = 1'b0;
      start_val  = score;
      sat_val    = '0;

      unique case (state)
         CLEAR: begin
            we_n      = 1'b1;
            wr_addr_n = clr_cnt;
            wr_data_n = 8'h20;
            clr_cnt_n = clr_cnt + 8'd1;
            if (clr_cnt == 8'(DEPTH - 1)) begin
               state_n   = LABEL;
               lbl_cnt_n = '0;
            end
         end
         LABEL: begin
            we_n      = 1'b1;
            wr_addr_n = 8'(LABEL_COL) + 8'(lbl_cnt);
            wr_data_n = label_char(lbl_cnt);
            lbl_cnt_n = lbl_cnt + 3'd1;
            exit_pt   = (lbl_cnt == 3'd4);
         end
         IDLE: begin
            busy_n  = 1'b0;
            exit_pt = 1'b1;
         end
         CONV: begin
            adj = dabble_adj(bcd);
            {bcd_n, bin_n} = {adj[BCD_W-2:0], bin, 1'b0};
            iter_cnt_n = iter_cnt + 1'b1;
            if (iter_cnt == IW'(SCORE_W - 2)) begin
               state_n   = WRITE;
               dig_cnt_n = '0;
            end
         end
         WRITE: begin
            we_n      = 1'b1;
            wr_addr_n = 8'(SCORE_COL) + 8'(dig_cnt);
            wr_data_n = 8'h30 + {4'h0, bcd[BCD_W-1 -: 4]};
            bcd_n     = bcd << 4;
            dig_cnt_n = dig_cnt + 1'b1;
            exit_pt   = (dig_cnt == DW'(DIGITS - 1));
         end
         default: state_n = CLEAR;
      endcase

      // At an exit point a fresh strobe beats the queued value; otherwise a
      // strobe while busy overwrites the one-deep pending slot.
      if (exit_pt) begin
         if (score_valid) begin
            start     = 1'b1;
            start_val = score;
         end else if (pend) begin
            start     = 1'b1;
            start_val = pend_val;
         end else begin
            state_n = IDLE;
         end
      end else if (score_valid) begin
         pend_n     = 1'b1;
         pend_val_n = score;
      end

      // Loading performs the first dabble iteration: BCD is zero, so no
      // correction is needed and the MSB shifts straight in.
      if (start) begin
         sat_val    = sat_score(start_val);
         state_n    = CONV;
         busy_n     = 1'b1;
         pend_n     = 1'b0;
         iter_cnt_n = '0;
         bcd_n      = {{(BCD_W-1){1'b0}}, sat_val[SCORE_W-1]};
         bin_n      = sat_val << 1;
      end
   end

   // Control state and registered outputs, cleared by the asynchronous reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         lbl_cnt  <= '0;
         iter_cnt <= '0;
         dig_cnt  <= '0;
         pend     <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 8'h00;
         we       <= 1'b0;
         busy     <= 1'b1;
      end else begin
         state    <= state_n;
         clr_cnt  <= clr_cnt_n;
         lbl_cnt  <= lbl_cnt_n;
         iter_cnt <= iter_cnt_n;
         dig_cnt  <= dig_cnt_n;
         pend     <= pend_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         we       <= we_n;
         busy     <= busy_n;
      end
   end

   // Datapath registers; only meaningful when the control state says so.
   always_ff @(posedge Clk) begin
      bin      <= bin_n;
      bcd      <= bcd_n;
      pend_val <= pend_val_n;
   end

endmodule
